// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: queues the prediction and the not-chosen path PC of each in-flight branch,
// checks it against the EX outcome, and drives predictor update, flush and redirect.
module branch_resolve_unit #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            fetch_branch,
    input  logic            fetch_pred,
    input  logic [PC_W-1:0] fetch_alt_pc,
    input  logic            ex_branch,
    input  logic            ex_taken,
    output logic            bpu_branch,
    output logic            bpu_miss,
    output logic            flush,
    output logic [PC_W-1:0] redirect_pc,
    output logic            stall_req,
    output logic            full,
    output logic            empty,
    output logic            err_underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        S_RUN,
        S_RECOVER
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             mem_pred [DEPTH];
    logic [PC_W-1:0]  mem_alt  [DEPTH];

    logic             active;
    logic             pop;
    logic             push;
    logic             miss;
    logic             push_eff;
    logic             underflow;
    logic             head_pred;
    logic [PC_W-1:0]  head_alt;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign stall_req = fetch_branch & full;

    assign head_pred = mem_pred[rd_ptr];
    assign head_alt  = mem_alt[rd_ptr];

    // In RECOVER the incoming branches are wrong-path, so nothing is pushed or popped.
    assign active    = (state == S_RUN) & ~stall;
    assign pop       = active & ex_branch & ~empty;
    assign push      = active & fetch_branch & (~full | pop);
    assign miss      = pop & (head_pred ^ ex_taken);
    assign push_eff  = push & ~miss;
    assign underflow = active & ex_branch & empty;

    // NOTE: queue storage has no reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem_pred[wr_ptr] <= fetch_pred;
            mem_alt[wr_ptr]  <= fetch_alt_pc;
        end
    end

    // NOTE: all state uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_RUN;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            bpu_branch    <= 1'b0;
            bpu_miss      <= 1'b0;
            flush         <= 1'b0;
            redirect_pc   <= '0;
            err_underflow <= 1'b0;
        end else begin
            bpu_branch <= pop;
            bpu_miss   <= miss;
            flush      <= miss;
            if (miss) begin
                redirect_pc <= head_alt;
            end
            if (underflow) begin
                err_underflow <= 1'b1;
            end

            if (miss) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                state  <= S_RECOVER;
            end else begin
                if (push_eff) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(push_eff) - CNT_W'(pop);
                if (state == S_RECOVER && !stall) begin
                    state <= S_RUN;
                end
            end
        end
    end

    a_count_bound : assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH));
    a_no_overflow : assert property (@(posedge clk) disable iff (rst) (push_eff & ~pop) |-> ~full);

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized self-checking bench for branch_resolve_unit against a queue-based reference model.
module tb_branch_resolve_unit;

    localparam int PC_W  = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            stall;
    logic            fetch_branch;
    logic            fetch_pred;
    logic [PC_W-1:0] fetch_alt_pc;
    logic            ex_branch;
    logic            ex_taken;
    logic            bpu_branch;
    logic            bpu_miss;
    logic            flush;
    logic [PC_W-1:0] redirect_pc;
    logic            stall_req;
    logic            full;
    logic            empty;
    logic            err_underflow;

    branch_resolve_unit #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .fetch_branch (fetch_branch),
        .fetch_pred   (fetch_pred),
        .fetch_alt_pc (fetch_alt_pc),
        .ex_branch    (ex_branch),
        .ex_taken     (ex_taken),
        .bpu_branch   (bpu_branch),
        .bpu_miss     (bpu_miss),
        .flush        (flush),
        .redirect_pc  (redirect_pc),
        .stall_req    (stall_req),
        .full         (full),
        .empty        (empty),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            pred;
        logic [PC_W-1:0] alt;
    } entry_t;

    entry_t          q[$];
    bit              m_recover;
    logic            m_branch;
    logic            m_miss;
    logic            m_flush;
    logic            m_err;
    logic [PC_W-1:0] m_redirect;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_recover  = 0;
        m_branch   = 0;
        m_miss     = 0;
        m_flush    = 0;
        m_err      = 0;
        m_redirect = '0;
    endtask

    task automatic model_step(input logic r, input logic s, input logic fb, input logic fp,
                              input logic [PC_W-1:0] fa, input logic eb, input logic et);
        bit run, do_pop, do_push, do_miss;
        if (r) begin
            model_reset();
            return;
        end
        run     = !m_recover && !s;
        do_pop  = run && eb && q.size() > 0;
        do_push = run && fb && (q.size() < DEPTH || do_pop);
        do_miss = do_pop && (q[0].pred != et);
        m_branch = do_pop;
        m_miss   = do_miss;
        m_flush  = do_miss;
        if (do_miss) m_redirect = q[0].alt;
        if (run && eb && q.size() == 0) m_err = 1;
        if (do_miss) begin
            q.delete();
            m_recover = 1;
        end else begin
            if (m_recover && !s) m_recover = 0;
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back('{pred: fp, alt: fa});
        end
    endtask

    // One clock cycle: drive, check combinational flags, advance model, check registered outputs.
    task automatic cycle(input logic r, input logic s, input logic fb, input logic fp,
                         input logic [PC_W-1:0] fa, input logic eb, input logic et);
        rst          = r;
        stall        = s;
        fetch_branch = fb;
        fetch_pred   = fp;
        fetch_alt_pc = fa;
        ex_branch    = eb;
        ex_taken     = et;
        #1;
        check("full_pre",  32'(full),      32'(q.size() == DEPTH));
        check("empty_pre", 32'(empty),     32'(q.size() == 0));
        check("stall_req", 32'(stall_req), 32'(fb && q.size() == DEPTH));
        model_step(r, s, fb, fp, fa, eb, et);
        @(posedge clk);
        #1;
        check("bpu_branch",    32'(bpu_branch),    32'(m_branch));
        check("bpu_miss",      32'(bpu_miss),      32'(m_miss));
        check("flush",         32'(flush),         32'(m_flush));
        check("redirect_pc",   redirect_pc,        m_redirect);
        check("err_underflow", 32'(err_underflow), 32'(m_err));
        check("full",          32'(full),          32'(q.size() == DEPTH));
        check("empty",         32'(empty),         32'(q.size() == 0));
    endtask

    initial begin
        rst = 1; stall = 0; fetch_branch = 0; fetch_pred = 0; fetch_alt_pc = '0;
        ex_branch = 0; ex_taken = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("reset_empty",    32'(empty),       32'd1);
        check("reset_full",     32'(full),        32'd0);
        check("reset_redirect", redirect_pc,      32'd0);
        check("reset_branch",   32'(bpu_branch),  32'd0);

        // Correct prediction round trip
        cycle(0, 0, 1, 1, 32'h104, 0, 0);
        cycle(0, 0, 0, 0, 32'h0,   1, 1);
        check("t1_branch", 32'(bpu_branch), 32'd1);
        check("t1_miss",   32'(bpu_miss),   32'd0);
        check("t1_empty",  32'(empty),      32'd1);

        // Mispredict, then RECOVER ignores a fetch_branch
        cycle(0, 0, 1, 0, 32'h200, 0, 0);
        cycle(0, 0, 0, 0, 32'h0,   1, 1);
        check("t2_flush",    32'(flush),  32'd1);
        check("t2_redirect", redirect_pc, 32'h200);
        cycle(0, 0, 1, 1, 32'h300, 0, 0);
        check("t2_recover_empty", 32'(empty), 32'd1);
        cycle(0, 0, 0, 0, 32'h0, 0, 0);

        // Fill to DEPTH, blocked push, then push with concurrent correct pop
        for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, 1, 32'h400 + 32'(i * 4), 0, 0);
        check("t3_full", 32'(full), 32'd1);
        cycle(0, 0, 1, 1, 32'h480, 0, 0);
        cycle(0, 0, 1, 0, 32'h500, 1, 1);
        check("t3_full_after_swap", 32'(full), 32'd1);

        // Down to 3 entries, then oldest mispredicts while fetch_branch pushes
        cycle(0, 0, 0, 0, 32'h0, 1, 1);
        cycle(0, 0, 1, 1, 32'h600, 1, 0);
        check("t4_empty", 32'(empty), 32'd1);
        check("t4_flush", 32'(flush), 32'd1);
        cycle(0, 0, 0, 0, 32'h0, 0, 0);

        // Stall freezes everything for 3 cycles
        cycle(0, 0, 1, 1, 32'h700, 0, 0);
        cycle(0, 0, 1, 0, 32'h704, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 1, 32'h800, 1, 0);
        cycle(0, 0, 0, 0, 32'h0, 1, 1);
        cycle(0, 0, 0, 0, 32'h0, 1, 0);
        cycle(0, 0, 0, 0, 32'h0, 0, 0);

        // Underflow is sticky until reset
        cycle(0, 0, 0, 0, 32'h0, 1, 1);
        check("t6_err",    32'(err_underflow), 32'd1);
        check("t6_branch", 32'(bpu_branch),    32'd0);
        cycle(1, 0, 0, 0, 32'h0, 0, 0);
        check("t6_err_cleared", 32'(err_underflow), 32'd0);
        check("t6_empty",       32'(empty),         32'd1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic r, s, fb, fp, eb, et;
            r  = ($urandom_range(99) == 0);
            s  = ($urandom_range(4) == 0);
            fb = ($urandom_range(1) == 1);
            fp = $urandom_range(1);
            eb = ($urandom_range(9) < 4);
            if (q.size() > 0 && $urandom_range(5) != 0) et = q[0].pred;
            else et = $urandom_range(1);
            cycle(r, s, fb, fp, $urandom, eb, et);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
